// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional range checking is enabled with the DMEM_RANGE_CHECK_EN macro.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } dmem_state_e;

    localparam int unsigned WORD_BYTES      = 4;
    localparam int unsigned WAIT_CNT_W      = 4;
    localparam int unsigned DEF_DEPTH_WORDS = 1024;
    localparam int unsigned DEF_WAIT_STATES = 2;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM with per-byte write enables and a
// registered, enable-gated read port that can be forced to zero.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter              MEM_INIT    = ""
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic                           we_i,
  input  logic [WORD_BYTES-1:0]          be_i,
  input  logic [8*WORD_BYTES-1:0]        wdata_i,
  input  logic                           rd_en_i,
  input  logic                           rd_clr_i,
  output logic [8*WORD_BYTES-1:0]        rdata_o
);

  logic [8*WORD_BYTES-1:0] mem_q [DEPTH_WORDS];
  logic [8*WORD_BYTES-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned b = 0; b < WORD_BYTES; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Read register holds its value between enabled reads.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (rd_en_i) begin
      rdata_q <= rd_clr_i ? '0 : mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Waitrequest-handshake data-memory responder for the pipeline memory stage.
// Define DMEM_RANGE_CHECK_EN to reject addresses beyond DEPTH_WORDS and drive o_p_err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int unsigned WAIT_STATES = DEF_WAIT_STATES,
    parameter              MEM_INIT    = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_p_addr,
    input  logic        i_p_read,
    input  logic        i_p_write,
    input  logic [31:0] i_p_writedata,
    input  logic [3:0]  i_p_byteenable,
    output logic [31:0] o_p_readdata,
`ifdef DMEM_RANGE_CHECK_EN
    output logic        o_p_err,
`endif
    output logic        o_p_waitrequest
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

    dmem_state_e           state_q;
    logic [WAIT_CNT_W-1:0] cnt_q;
    logic                  req;
    logic                  enter_ack;
    logic                  in_range;
    logic [AW-1:0]         word_idx;
    logic                  ram_we;
    logic                  ram_rd_en;
    logic                  ram_rd_clr;
    logic                  unused_addr_bits;

    assign req      = i_p_read | i_p_write;
    assign word_idx = i_p_addr[2 +: AW];

`ifdef DMEM_RANGE_CHECK_EN
    logic err_q;
    assign in_range         = (i_p_addr >> (AW + 2)) == '0;
    assign unused_addr_bits = ^i_p_addr[1:0];
    assign o_p_err          = err_q;
`else
    assign in_range         = 1'b1;
    assign unused_addr_bits = ^{i_p_addr[31:AW+2], i_p_addr[1:0]};
`endif

    // The counter is loaded with WAIT_STATES and ACK is entered on the edge
    // where it would reach zero, so BUSY lasts exactly WAIT_STATES cycles and
    // a zero-wait configuration goes straight from the request cycle to ACK.
    always_comb begin
        enter_ack = 1'b0;
        case (state_q)
            IDLE:    enter_ack = req && (WAIT_STATES == 0);
            BUSY:    enter_ack = req && (cnt_q <= WAIT_CNT_W'(1));
            default: enter_ack = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
`ifdef DMEM_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
`ifdef DMEM_RANGE_CHECK_EN
            err_q <= enter_ack & ~in_range;
`endif
            case (state_q)
                IDLE: begin
                    if (enter_ack) begin
                        state_q <= ACK;
                    end else if (req) begin
                        state_q <= BUSY;
                        cnt_q   <= WAIT_INIT;
                    end
                end
                BUSY: begin
                    if (!req) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (enter_ack) begin
                        state_q <= ACK;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Write wins over a simultaneous read; writes commit at the end of ACK.
    assign ram_we     = (state_q == ACK) & i_p_write & in_range;
    assign ram_rd_en  = enter_ack & i_p_read & ~i_p_write;
    assign ram_rd_clr = ~in_range;

    assign o_p_waitrequest = req & (state_q != ACK);

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .MEM_INIT    (MEM_INIT)
    ) u_ram (
        .clk_i    (clk),
        .rst_i    (rst),
        .addr_i   (word_idx),
        .we_i     (ram_we),
        .be_i     (i_p_byteenable),
        .wdata_i  (i_p_writedata),
        .rd_en_i  (ram_rd_en),
        .rd_clr_i (ram_rd_clr),
        .rdata_o  (o_p_readdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a transfer-level model predicts waitrequest,
// readdata and err every cycle for a 2-wait-state and a 0-wait-state instance.
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int W0    = 2;
    localparam int W1    = 0;
`ifdef DMEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p_read  [2];
    logic        p_write [2];
    logic [31:0] p_addr  [2];
    logic [31:0] p_wdata [2];
    logic [3:0]  p_be    [2];
    logic [31:0] p_rdata [2];
    logic        p_wait  [2];
`ifdef DMEM_RANGE_CHECK_EN
    logic        p_err   [2];
`endif

    int          total = 0;
    int          bad   = 0;
    bit          chk_en = 1'b0;
    int          ws [2];
    logic        exp_wait [2];
    logic [31:0] exp_rd   [2];
    logic        exp_err  [2];
    logic [31:0] mmem [2][DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_STATES (W0),
        .MEM_INIT    ("")
    ) u_a (
        .clk             (clk),
        .rst             (rst),
        .i_p_addr        (p_addr[0]),
        .i_p_read        (p_read[0]),
        .i_p_write       (p_write[0]),
        .i_p_writedata   (p_wdata[0]),
        .i_p_byteenable  (p_be[0]),
        .o_p_readdata    (p_rdata[0]),
`ifdef DMEM_RANGE_CHECK_EN
        .o_p_err         (p_err[0]),
`endif
        .o_p_waitrequest (p_wait[0])
    );

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_STATES (W1),
        .MEM_INIT    ("")
    ) u_b (
        .clk             (clk),
        .rst             (rst),
        .i_p_addr        (p_addr[1]),
        .i_p_read        (p_read[1]),
        .i_p_write       (p_write[1]),
        .i_p_writedata   (p_wdata[1]),
        .i_p_byteenable  (p_be[1]),
        .o_p_readdata    (p_rdata[1]),
`ifdef DMEM_RANGE_CHECK_EN
        .o_p_err         (p_err[1]),
`endif
        .o_p_waitrequest (p_wait[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int s = 0; s < 2; s++) begin
                chk(s == 0 ? "a_waitreq" : "b_waitreq", {31'b0, p_wait[s]}, {31'b0, exp_wait[s]});
                chk(s == 0 ? "a_readdata" : "b_readdata", p_rdata[s], exp_rd[s]);
`ifdef DMEM_RANGE_CHECK_EN
                chk(s == 0 ? "a_err" : "b_err", {31'b0, p_err[s]}, {31'b0, exp_err[s]});
`endif
            end
        end
    end

    task automatic drive(input int s, input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be);
        p_read[s]  = rd;
        p_write[s] = wr;
        p_addr[s]  = addr;
        p_wdata[s] = wd;
        p_be[s]    = be;
    endtask

    task automatic idle(input int s);
        drive(s, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        exp_wait[s] = 1'b0;
        exp_err[s]  = 1'b0;
        @(posedge clk); #1;
    endtask

    // One transfer: waitrequest high for ws+1 cycles, then one ACK cycle.
    // drop_at >= 0 withdraws the request in that cycle of the transfer.
    task automatic xfer(input int s, input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input int drop_at);
        int idx;
        bit inr;
        idx = int'((addr >> 2) % DEPTH);
        inr = !RC || (addr < 32'(DEPTH * 4));
        drive(s, rd, wr, addr, wd, be);
        for (int k = 0; k <= ws[s] + 1; k++) begin
            if (k == drop_at) begin
                drive(s, 1'b0, 1'b0, addr, wd, be);
                exp_wait[s] = 1'b0;
                exp_err[s]  = 1'b0;
                @(posedge clk); #1;
                return;
            end
            exp_wait[s] = (k <= ws[s]);
            exp_err[s]  = 1'b0;
            if (k == ws[s] + 1) begin
                if (rd && !wr) exp_rd[s] = inr ? mmem[s][idx] : 32'h0;
                exp_err[s] = RC && !inr;
            end
            @(posedge clk); #1;
        end
        exp_err[s] = 1'b0;
        if (wr && inr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mmem[s][idx][8*b +: 8] = wd[8*b +: 8];
            end
        end
    endtask

    initial begin
        ws[0] = W0;
        ws[1] = W1;
        for (int s = 0; s < 2; s++) begin
            drive(s, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            exp_wait[s] = 1'b0;
            exp_rd[s]   = 32'h0;
            exp_err[s]  = 1'b0;
            for (int i = 0; i < DEPTH; i++) mmem[s][i] = 32'h0;
        end
        rst    = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Write then read back
        xfer(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, -1);
        idle(0);
        xfer(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, -1);
        chk("a_rd40_lit", p_rdata[0], 32'hDEADBEEF);
        chk("model_40", mmem[0][16], 32'hDEADBEEF);
        idle(0);

        // Byte enables
        xfer(0, 1'b0, 1'b1, 32'h8, 32'h11223344, 4'hF, -1);
        xfer(0, 1'b0, 1'b1, 32'h8, 32'h000000AA, 4'b0001, -1);
        xfer(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, -1);
        chk("a_be_lit", p_rdata[0], 32'h112233AA);
        chk("model_be", mmem[0][2], 32'h112233AA);
        idle(0);

        // Reset in the second BUSY cycle of a write
        xfer(0, 1'b0, 1'b1, 32'h10, 32'h0BADF00D, 4'hF, -1);
        idle(0);
        drive(0, 1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'hF);
        exp_wait[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst       = 1'b1;
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        #1;
        chk("a_rst_rd_lit", p_rdata[0], 32'h0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        exp_wait[0] = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        xfer(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, -1);
        chk("a_rst_keep_lit", p_rdata[0], 32'h0BADF00D);
        idle(0);

        // Read and write together: write wins, readdata holds
        xfer(0, 1'b1, 1'b1, 32'h20, 32'h5, 4'hF, -1);
        chk("a_rw_hold_lit", p_rdata[0], 32'h0BADF00D);
        idle(0);
        xfer(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, -1);
        chk("a_rw_commit_lit", p_rdata[0], 32'h5);
        idle(0);

        // Request withdrawn in BUSY
        xfer(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1);
        idle(0);
        chk("a_drop_rd_lit", p_rdata[0], 32'h5);
        xfer(0, 1'b0, 1'b1, 32'h40, 32'h0, 4'hF, 2);
        idle(0);
        xfer(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, -1);
        chk("a_drop_wr_lit", p_rdata[0], 32'hDEADBEEF);
        idle(0);

        // Out-of-range address DEPTH*4
        xfer(0, 1'b0, 1'b1, 32'h0, 32'h12345678, 4'hF, -1);
        xfer(0, 1'b0, 1'b1, 32'(DEPTH * 4), 32'h00000077, 4'hF, -1);
        idle(0);
        xfer(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, -1);
        chk("a_oor_wr_lit", p_rdata[0], RC ? 32'h12345678 : 32'h00000077);
        idle(0);
        xfer(0, 1'b1, 1'b0, 32'(DEPTH * 4), 32'h0, 4'h0, -1);
        chk("a_oor_rd_lit", p_rdata[0], RC ? 32'h0 : 32'h00000077);
        idle(0);

        // Zero wait states, back-to-back transfers with the request held
        xfer(1, 1'b0, 1'b1, 32'h0, 32'hA0A0A0A0, 4'hF, -1);
        xfer(1, 1'b0, 1'b1, 32'h4, 32'hB1B1B1B1, 4'hF, -1);
        idle(1);
        xfer(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, -1);
        chk("b_rd0_lit", p_rdata[1], 32'hA0A0A0A0);
        xfer(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, -1);
        chk("b_rd4_lit", p_rdata[1], 32'hB1B1B1B1);
        idle(1);
        idle(1);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
